// File: rtl/router_pkt_drain.sv
// Drains one complete packet (header, payload, parity) from a router output-port FIFO.
// Header and payload go out on a valid/ready stream. Parity is checked and not forwarded.
module router_pkt_drain #(
    parameter logic [1:0] PORT_ID     = 2'd0,
    parameter int         STALL_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vald_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sop,
    output logic       m_eop,
    output logic       pkt_done,
    output logic [1:0] pkt_err,
    output logic       pkt_abort
);

    typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

    localparam logic [4:0] STALL_LAST = 5'(STALL_LIMIT - 1);

    state_t     state, state_nxt;

    // Each buffer entry is {sop, eop, data}.
    logic [9:0] buf_mem [2];
    logic       rd_ptr, wr_ptr;
    logic [1:0] occ;
    logic [9:0] head;
    logic       push, pop, room;
    logic [9:0] push_entry;

    logic       rd_pending;
    logic [5:0] len, cap_cnt;
    logic [6:0] remaining;
    logic [7:0] par_acc;
    logic       addr_err, par_err;
    logic [4:0] stall_cnt;
    logic       stall, abort_now;
    logic       cap_hdr, cap_body, is_parity;

    always_comb begin
        head      = buf_mem[rd_ptr];
        m_valid   = (occ != 2'd0);
        m_data    = m_valid ? head[7:0] : 8'h00;
        m_sop     = m_valid && head[9];
        m_eop     = m_valid && head[8];
        pop       = m_valid && m_ready;
        // Count the slot freed by this cycle's pop so the stream sustains one byte per cycle.
        room      = (({1'b0, occ} - {2'b00, pop} + {2'b00, rd_pending}) < 3'd2);
        stall     = (state == BODY) && (remaining != 7'd0) && !vald_out;
        abort_now = stall && (stall_cnt == STALL_LAST);
        cap_hdr   = (state == HDR) && rd_pending;
        cap_body  = (state == BODY) && rd_pending;
        is_parity = cap_body && (cap_cnt == len);
        push      = cap_hdr || (cap_body && !is_parity);
        if (cap_hdr) begin
            push_entry = {1'b1, (data_out[7:2] == 6'd0), data_out};
        end else begin
            push_entry = {1'b0, ((cap_cnt + 6'd1) == len), data_out};
        end
    end

    always_comb begin
        state_nxt = state;
        read_enb  = 1'b0;
        pkt_done  = 1'b0;
        pkt_err   = 2'b00;
        pkt_abort = 1'b0;
        case (state)
            IDLE: begin
                read_enb = vald_out && room;
                if (read_enb) state_nxt = HDR;
            end
            HDR: begin
                state_nxt = BODY;
            end
            BODY: begin
                read_enb = vald_out && (remaining != 7'd0) && room;
                if (abort_now) begin
                    pkt_abort = 1'b1;
                    state_nxt = IDLE;
                end else if (is_parity) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The next header is left in the FIFO until this packet has fully left the buffer.
                if (occ == 2'd0) begin
                    pkt_done  = 1'b1;
                    pkt_err   = {addr_err, par_err};
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) read_enb = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_pending <= read_enb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            occ        <= 2'd0;
        end else if (abort_now) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len       <= 6'd0;
            cap_cnt   <= 6'd0;
            remaining <= 7'd0;
            par_acc   <= 8'h00;
            addr_err  <= 1'b0;
            par_err   <= 1'b0;
            stall_cnt <= 5'd0;
        end else if (cap_hdr) begin
            len       <= data_out[7:2];
            cap_cnt   <= 6'd0;
            remaining <= {1'b0, data_out[7:2]} + 7'd1;
            par_acc   <= data_out;
            addr_err  <= (data_out[1:0] != PORT_ID);
            par_err   <= 1'b0;
            stall_cnt <= 5'd0;
        end else if (state == BODY) begin
            if (read_enb) remaining <= remaining - 7'd1;
            if (cap_body && !is_parity) begin
                par_acc <= par_acc ^ data_out;
                cap_cnt <= cap_cnt + 6'd1;
            end
            if (is_parity) par_err <= (par_acc != data_out);
            if (read_enb || abort_now) begin
                stall_cnt <= 5'd0;
            end else if (stall) begin
                stall_cnt <= stall_cnt + 5'd1;
            end
        end else begin
            stall_cnt <= 5'd0;
        end
    end

endmodule

// File: tb/tb_router_pkt_drain.sv
// Bench for router_pkt_drain: behavioural router FIFO source, stream monitor, and vector table.
// Directed sequences cover backpressure, stall abort and reset.
module tb_router_pkt_drain;

    logic       clk = 1'b0;
    logic       rst, vald_out, m_ready;
    logic [7:0] data_out;
    logic       read_enb, m_valid, m_sop, m_eop, pkt_done, pkt_abort;
    logic [7:0] m_data;
    logic [1:0] pkt_err;

    always #5 clk = ~clk;

    router_pkt_drain #(.PORT_ID(2'd0), .STALL_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .vald_out(vald_out), .data_out(data_out), .read_enb(read_enb),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .pkt_abort(pkt_abort)
    );

    typedef struct {
        logic [7:0]  hdr;
        logic [63:0] pay;
        logic [7:0]  parity;
        logic [1:0]  exp_err;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] src_q[$];
    logic       hold = 1'b0;
    logic       re_s = 1'b0;
    logic [9:0] got_q[$];
    int         done_cnt = 0, abort_cnt = 0, read_cnt = 0, cyc = 0;
    int         last_read_cyc = 0, abort_cyc = 0;
    logic [1:0] last_err = 2'b00;
    vec_t       vecs[6];

    // Router port FIFO: data appears on data_out the cycle after read_enb.
    initial begin
        vald_out = 1'b0;
        data_out = 8'h00;
        forever begin
            @(negedge clk);
            re_s = read_enb;
            @(posedge clk);
            #1;
            if (re_s && src_q.size() > 0) data_out = src_q.pop_front();
            vald_out = (src_q.size() > 0) && !hold;
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_valid && m_ready) got_q.push_back({m_sop, m_eop, m_data});
        if (read_enb) begin
            read_cnt      = read_cnt + 1;
            last_read_cyc = cyc;
        end
        if (pkt_done) begin
            done_cnt = done_cnt + 1;
            last_err = pkt_err;
        end
        if (pkt_abort) begin
            abort_cnt = abort_cnt + 1;
            abort_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_cnt  = 0;
        abort_cnt = 0;
        read_cnt  = 0;
    endtask

    task automatic push_packet(input vec_t v);
        src_q.push_back(v.hdr);
        for (int i = 0; i < int'(v.hdr[7:2]); i++) src_q.push_back(v.pay[8*i +: 8]);
        src_q.push_back(v.parity);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            step();
            n++;
        end
        if (done_cnt == 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL done_timeout: got no pkt_done expected pkt_done within %0d cycles", limit);
        end
        step();
        step();
    endtask

    task automatic apply_stimulus(input vec_t v);
        clear_mon();
        m_ready = 1'b1;
        push_packet(v);
        wait_done(200);
    endtask

    task automatic check_output(input vec_t v, input string tag);
        int         len;
        logic [9:0] exp;
        len = int'(v.hdr[7:2]);
        check({tag, " beats"}, got_q.size(), len + 1);
        for (int i = 0; i <= len && i < got_q.size(); i++) begin
            if (i == 0) exp = {1'b1, (len == 0), v.hdr};
            else        exp = {1'b0, (i == len), v.pay[8*(i-1) +: 8]};
            check($sformatf("%s beat%0d", tag, i), got_q[i], exp);
        end
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " pkt_err"}, last_err, v.exp_err);
        check({tag, " reads"}, read_cnt, len + 2);
        check({tag, " abort_cnt"}, abort_cnt, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " outs"},
              {read_enb, m_valid, m_data, m_sop, m_eop, pkt_done, pkt_err, pkt_abort}, 0);
    endtask

    initial begin
        int         n;
        int         r0;
        vec_t       bad;
        vecs[0] = '{8'h0C, 64'h0000_0000_0033_2211, 8'h0C, 2'b00};
        vecs[1] = '{8'h0C, 64'h0000_0000_0033_2211, 8'hFF, 2'b01};
        vecs[2] = '{8'h05, 64'h0000_0000_0000_00AA, 8'hAF, 2'b10};
        vecs[3] = '{8'h08, 64'h0000_0000_0000_A55A, 8'hF7, 2'b00};
        vecs[4] = '{8'h00, 64'h0000_0000_0000_0000, 8'h00, 2'b00};
        vecs[5] = '{8'h05, 64'h0000_0000_0000_00AA, 8'h00, 2'b11};

        rst     = 1'b1;
        m_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check_idle_outputs("reset");
        step();

        for (int k = 0; k < 6; k++) begin
            apply_stimulus(vecs[k]);
            check_output(vecs[k], $sformatf("vec%0d", k));
        end

        // Sink stalls right after the header: the buffer fills to two and reads stop.
        clear_mon();
        m_ready = 1'b0;
        push_packet(vecs[0]);
        n = 0;
        while (!m_valid && n < 50) begin
            step();
            n++;
        end
        r0 = read_cnt;
        repeat (5) step();
        check("bp stall_reads", read_cnt - r0, 1);
        check("bp hold_head", {m_valid, m_sop, m_eop, m_data}, {1'b1, 1'b1, 1'b0, 8'h0C});
        m_ready = 1'b1;
        wait_done(200);
        check_output(vecs[0], "bp");

        // FIFO runs dry after two payload bytes of a five-byte packet.
        clear_mon();
        m_ready = 1'b1;
        src_q.push_back(8'h14);
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        n = 0;
        while (abort_cnt == 0 && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
        check("abort pulses", abort_cnt, 1);
        check("abort no_done", done_cnt, 0);
        check("abort stall_len", abort_cyc - last_read_cyc, 16);
        check("abort beats", got_q.size(), 3);
        check("abort reads", read_cnt, 3);
        check("abort m_valid", m_valid, 0);
        apply_stimulus(vecs[0]);
        check_output(vecs[0], "after_abort");

        // Reset in the middle of a packet body with bytes still buffered.
        clear_mon();
        m_ready = 1'b0;
        bad = '{8'h14, 64'h0000_0005_0403_0201, 8'h00, 2'b00};
        push_packet(bad);
        n = 0;
        while (read_cnt < 3 && n < 50) begin
            step();
            n++;
        end
        hold = 1'b1;
        src_q.delete();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("midrst");
        hold = 1'b0;
        step();
        apply_stimulus(vecs[3]);
        check_output(vecs[3], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
